// File: rtl/me_pkg.sv
// Shared types for the motion-estimation result output stage: default field
// widths, the result record layout and the serializer state encoding.
package me_pkg;

  localparam int ME_SAD_W = 14;
  localparam int ME_MV_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Reference layout at default widths; modules re-declare it at their own widths.
  typedef struct packed {
    logic [ME_SAD_W-1:0] sad;
    logic [ME_MV_W-1:0]  mv_x;
    logic [ME_MV_W-1:0]  mv_y;
  } me_result_t;

  function automatic int me_result_width(input int sad_w, input int mv_w);
    return sad_w + 2 * mv_w;
  endfunction

endpackage

// File: rtl/me_result_serializer_if.sv
// Result handshake and serial-lane bundle between the ME decision logic
// (master) and the result serializer (slave).
interface me_result_serializer_if
  import me_pkg::*;
#(
  parameter int SAD_W = ME_SAD_W,
  parameter int MV_W  = ME_MV_W,
  parameter int DEPTH = 4
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [SAD_W-1:0] in_sad;
  logic [MV_W-1:0]  in_mv_x;
  logic [MV_W-1:0]  in_mv_y;
  logic             ser_sad;
  logic             ser_x;
  logic             ser_y;
  logic             ser_sad_vld;
  logic             ser_mv_vld;
  logic             ser_sof;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output in_valid, in_sad, in_mv_x, in_mv_y,
    input  in_ready, ser_sad, ser_x, ser_y, ser_sad_vld, ser_mv_vld, ser_sof,
           fifo_level
  );

  modport slave (
    input  in_valid, in_sad, in_mv_x, in_mv_y,
    output in_ready, ser_sad, ser_x, ser_y, ser_sad_vld, ser_mv_vld, ser_sof,
           fifo_level
  );

endinterface

// File: rtl/me_result_fifo.sv
// Synchronous FIFO with registered occupancy; push is ignored when full and
// pop is ignored when empty. DEPTH must be a power of two so pointers wrap.
module me_result_fifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/me_result_serializer.sv
// Buffers {SAD, MV x, MV y} results and shifts each one out MSB-first on three
// parallel lanes with framing strobes; one SAD_W-cycle frame per result.
module me_result_serializer
  import me_pkg::*;
#(
  parameter int SAD_W = ME_SAD_W,
  parameter int MV_W  = ME_MV_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  me_result_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(SAD_W);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  mv_x;
    logic [MV_W-1:0]  mv_y;
  } result_t;

  localparam int RES_W = me_result_width(SAD_W, MV_W);

  result_t          wr_word;
  result_t          rd_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             pop;
  logic             load;

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SAD_W-1:0] sad_sr_q, sad_sr_d;
  logic [MV_W-1:0]  x_sr_q, x_sr_d;
  logic [MV_W-1:0]  y_sr_q, y_sr_d;
  logic             sad_vld_q, sad_vld_d;
  logic             mv_vld_q, mv_vld_d;
  logic             sof_q, sof_d;

  assign wr_word = {bus.in_sad, bus.in_mv_x, bus.in_mv_y};

  me_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.in_valid),
    .wr_data (wr_word),
    .pop     (pop),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // A pop never frees a slot for a same-edge push: ready follows the level only
  assign bus.in_ready    = ~fifo_full;
  assign bus.fifo_level  = fifo_level;
  assign bus.ser_sad     = sad_sr_q[SAD_W-1];
  assign bus.ser_x       = x_sr_q[MV_W-1];
  assign bus.ser_y       = y_sr_q[MV_W-1];
  assign bus.ser_sad_vld = sad_vld_q;
  assign bus.ser_mv_vld  = mv_vld_q;
  assign bus.ser_sof     = sof_q;

  // Serializer next state, shift registers and framing strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sad_sr_d = sad_sr_q << 1'b1;
    x_sr_d   = x_sr_q << 1'b1;
    y_sr_d   = y_sr_q << 1'b1;
    load     = 1'b0;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        sad_sr_d = '0;
        x_sr_d   = '0;
        y_sr_d   = '0;
        if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(SAD_W - 1)) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            load    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          load  = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        sad_sr_d = '0;
        x_sr_d   = '0;
        y_sr_d   = '0;
        load     = 1'b0;
      end
    endcase

    // Loading always overrides the shift so back-to-back frames have no gap
    if (load) begin
      pop      = 1'b1;
      state_d  = SHIFT;
      cnt_d    = '0;
      sad_sr_d = rd_word.sad;
      x_sr_d   = rd_word.mv_x;
      y_sr_d   = rd_word.mv_y;
    end else begin
      pop = 1'b0;
    end

    sad_vld_d = (state_d == SHIFT);
    sof_d     = load;
    mv_vld_d  = (state_d == SHIFT) && (32'(cnt_d) < 32'(MV_W));
  end

  // Serializer state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sad_sr_q  <= '0;
      x_sr_q    <= '0;
      y_sr_q    <= '0;
      sad_vld_q <= 1'b0;
      mv_vld_q  <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sad_sr_q  <= sad_sr_d;
      x_sr_q    <= x_sr_d;
      y_sr_q    <= y_sr_d;
      sad_vld_q <= sad_vld_d;
      mv_vld_q  <= mv_vld_d;
      sof_q     <= sof_d;
    end
  end

endmodule

// File: tb/tb_me_result_serializer.sv
// Bench for me_result_serializer: directed frame checks on the default
// parameter set plus random traffic on SAD_W=16, MV_W=6, DEPTH=8.
module tb_me_result_serializer;

  localparam int A_SAD = 14, A_MV = 4, A_DEPTH = 4;
  localparam int B_SAD = 16, B_MV = 6, B_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  me_result_serializer_if #(.SAD_W(A_SAD), .MV_W(A_MV), .DEPTH(A_DEPTH)) a ();
  me_result_serializer_if #(.SAD_W(B_SAD), .MV_W(B_MV), .DEPTH(B_DEPTH)) b ();

  me_result_serializer #(.SAD_W(A_SAD), .MV_W(A_MV), .DEPTH(A_DEPTH)) u_dut_a (
    .clk (clk), .rst (rst), .bus (a.slave));
  me_result_serializer #(.SAD_W(B_SAD), .MV_W(B_MV), .DEPTH(B_DEPTH)) u_dut_b (
    .clk (clk), .rst (rst), .bus (b.slave));

  typedef struct {
    int unsigned sad;
    int unsigned x;
    int unsigned y;
    int unsigned len;
    int unsigned mvlen;
  } frame_t;

  frame_t exp_a[$], got_a[$], exp_b[$], got_b[$];
  frame_t ma_cur, mb_cur;
  bit ma_in, mb_in;
  int ma_bad, mb_bad;
  int checks = 0;
  int failures = 0;

  // Reassemble frames from the lanes: a frame starts on sof and ends when the
  // next sof arrives or ser_sad_vld drops.
  task automatic mon_sample();
    if (rst) begin
      ma_in = 1'b0;
      mb_in = 1'b0;
    end else begin
      if (ma_in && (!a.ser_sad_vld || a.ser_sof)) begin got_a.push_back(ma_cur); ma_in = 1'b0; end
      if (a.ser_sad_vld && a.ser_sof) begin ma_in = 1'b1; ma_cur = '{0, 0, 0, 0, 0}; end
      if (ma_in && a.ser_sad_vld) begin
        ma_cur.sad = (ma_cur.sad << 1) | 32'(a.ser_sad);
        ma_cur.len++;
        if (a.ser_mv_vld) begin
          ma_cur.x = (ma_cur.x << 1) | 32'(a.ser_x);
          ma_cur.y = (ma_cur.y << 1) | 32'(a.ser_y);
          ma_cur.mvlen++;
        end
      end
      if (!a.ser_mv_vld && (a.ser_x || a.ser_y)) ma_bad++;
      if (!a.ser_sad_vld && (a.ser_sad || a.ser_sof || a.ser_mv_vld)) ma_bad++;

      if (mb_in && (!b.ser_sad_vld || b.ser_sof)) begin got_b.push_back(mb_cur); mb_in = 1'b0; end
      if (b.ser_sad_vld && b.ser_sof) begin mb_in = 1'b1; mb_cur = '{0, 0, 0, 0, 0}; end
      if (mb_in && b.ser_sad_vld) begin
        mb_cur.sad = (mb_cur.sad << 1) | 32'(b.ser_sad);
        mb_cur.len++;
        if (b.ser_mv_vld) begin
          mb_cur.x = (mb_cur.x << 1) | 32'(b.ser_x);
          mb_cur.y = (mb_cur.y << 1) | 32'(b.ser_y);
          mb_cur.mvlen++;
        end
      end
      if (!b.ser_mv_vld && (b.ser_x || b.ser_y)) mb_bad++;
      if (!b.ser_sad_vld && (b.ser_sad || b.ser_sof || b.ser_mv_vld)) mb_bad++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_sample();
  endtask

  task automatic drive_a(input bit v, input int unsigned s, input int unsigned x, input int unsigned y);
    a.in_valid = v;
    a.in_sad   = 14'(s);
    a.in_mv_x  = 4'(x);
    a.in_mv_y  = 4'(y);
  endtask

  task automatic drain_a(output bit timed_out);
    int n = 0;
    while ((a.fifo_level != 3'd0 || a.ser_sad_vld) && n < 300) begin
      tick();
      n++;
    end
    timed_out = (n >= 300);
  endtask

  task automatic test_reset();
    drive_a(1'b0, 0, 0, 0);
    b.in_valid = 1'b0; b.in_sad = '0; b.in_mv_x = '0; b.in_mv_y = '0;
    rst = 1'b1;
    #12;
    checks++;
    if ({a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof} !== 6'b0) begin
      failures++;
      $display("FAIL reset_lanes_a got=%b exp=000000", {a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof});
    end
    checks++;
    if (a.fifo_level !== 3'd0 || a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_level_ready_a got=%0d/%b exp=0/1", a.fifo_level, a.in_ready);
    end
    checks++;
    if ({b.ser_sad, b.ser_x, b.ser_y, b.ser_sad_vld, b.ser_mv_vld, b.ser_sof} !== 6'b0 ||
        b.fifo_level !== 4'd0 || b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_b got lanes=%b level=%0d ready=%b exp=0/0/1",
               {b.ser_sad, b.ser_x, b.ser_y, b.ser_sad_vld, b.ser_mv_vld, b.ser_sof}, b.fifo_level, b.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (a.ser_sad_vld !== 1'b0 || a.fifo_level !== 3'd0 || a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_idle got vld=%b level=%0d ready=%b", a.ser_sad_vld, a.fifo_level, a.in_ready);
    end
  endtask

  task automatic test_single_word();
    logic [13:0] sv = 14'h2A5C;
    logic [3:0]  xv = 4'hA;
    logic [3:0]  yv = 4'h3;
    logic [5:0]  e;
    bit to;
    got_a.delete();
    ma_bad = 0;
    drive_a(1'b1, 32'(sv), 32'(xv), 32'(yv));
    tick();
    a.in_valid = 1'b0;
    checks++;
    if (a.fifo_level !== 3'd1 || a.ser_sad_vld !== 1'b0) begin
      failures++;
      $display("FAIL single_buffered got level=%0d vld=%b exp=1/0", a.fifo_level, a.ser_sad_vld);
    end
    tick();
    for (int i = 0; i < A_SAD; i++) begin
      e[5] = sv[13-i];
      e[4] = (i < A_MV) ? xv[3-i] : 1'b0;
      e[3] = (i < A_MV) ? yv[3-i] : 1'b0;
      e[2] = 1'b1;
      e[1] = (i < A_MV);
      e[0] = (i == 0);
      checks++;
      if ({a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof} !== e) begin
        failures++;
        $display("FAIL single_bit%0d got=%b exp=%b", i, {a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof}, e);
      end
      tick();
    end
    checks++;
    if ({a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof} !== 6'b0 || a.fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL single_back_to_idle got lanes=%b level=%0d",
               {a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof}, a.fifo_level);
    end
    drain_a(to);
    checks++;
    if (got_a.size() != 1 || ma_bad != 0) begin
      failures++;
      $display("FAIL single_frame_count got=%0d bad=%0d exp=1/0", got_a.size(), ma_bad);
    end
  endtask

  task automatic test_back_to_back();
    bit vld_h[60];
    bit sof_h[60];
    int first = -1;
    int run = 0;
    int nsof = 0;
    bit sof_ok = 1'b1;
    bit to;
    got_a.delete();
    exp_a.delete();
    for (int c = 0; c < 60; c++) begin
      if (c < 3) begin
        frame_t f;
        f = '{$urandom_range(0, 16383), $urandom_range(0, 15), $urandom_range(0, 15), A_SAD, A_MV};
        drive_a(1'b1, f.sad, f.x, f.y);
        exp_a.push_back(f);
      end else begin
        a.in_valid = 1'b0;
      end
      tick();
      vld_h[c] = a.ser_sad_vld;
      sof_h[c] = a.ser_sof;
    end
    for (int c = 0; c < 60; c++) if (vld_h[c] && first < 0) first = c;
    for (int c = (first < 0) ? 0 : first; c < 60 && first >= 0 && vld_h[c]; c++) run++;
    for (int c = 0; c < 60; c++) begin
      if (sof_h[c]) begin
        nsof++;
        if (!(c == first || c == first + A_SAD || c == first + 2 * A_SAD)) sof_ok = 1'b0;
      end
    end
    checks++;
    if (first != 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", first); end
    checks++;
    if (run != 3 * A_SAD) begin failures++; $display("FAIL b2b_vld_run got=%0d exp=%0d", run, 3 * A_SAD); end
    checks++;
    if (nsof != 3 || !sof_ok) begin failures++; $display("FAIL b2b_sof_offsets got count=%0d ok=%b exp=3/1", nsof, sof_ok); end
    drain_a(to);
    checks++;
    if (got_a.size() != 3) begin
      failures++;
      $display("FAIL b2b_frames got=%0d exp=3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_a[i] != exp_a[i]) begin
          failures++;
          $display("FAIL b2b_word%0d got=%h/%h/%h len=%0d exp=%h/%h/%h len=%0d", i, got_a[i].sad, got_a[i].x,
                   got_a[i].y, got_a[i].len, exp_a[i].sad, exp_a[i].x, exp_a[i].y, exp_a[i].len);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    frame_t w[6];
    int idx = 0;
    int ready_h[40], level_h[40], idx_h[40];
    int low_run = 0;
    bit was_ready;
    bit to;
    got_a.delete();
    exp_a.delete();
    for (int i = 0; i < 6; i++)
      w[i] = '{$urandom_range(0, 16383), $urandom_range(0, 15), $urandom_range(0, 15), A_SAD, A_MV};
    drive_a(1'b1, w[0].sad, w[0].x, w[0].y);
    for (int c = 0; c < 40; c++) begin
      was_ready = a.in_ready;
      tick();
      if (was_ready && a.in_valid) begin
        exp_a.push_back(w[idx]);
        idx++;
        if (idx == 6) a.in_valid = 1'b0;
        else drive_a(1'b1, w[idx].sad, w[idx].x, w[idx].y);
      end
      ready_h[c] = int'(a.in_ready);
      level_h[c] = int'(a.fifo_level);
      idx_h[c]   = idx;
    end
    checks++;
    if (idx_h[4] != A_DEPTH + 1 || ready_h[4] != 0 || level_h[4] != A_DEPTH) begin
      failures++;
      $display("FAIL bp_fill got accepted=%0d ready=%0d level=%0d exp=%0d/0/%0d", idx_h[4], ready_h[4], level_h[4], A_DEPTH + 1, A_DEPTH);
    end
    for (int c = 4; c < 40 && ready_h[c] == 0; c++) low_run++;
    checks++;
    if (low_run != A_SAD + 1 - A_DEPTH) begin
      failures++;
      $display("FAIL bp_ready_low_cycles got=%0d exp=%0d", low_run, A_SAD + 1 - A_DEPTH);
    end
    checks++;
    if (ready_h[15] != 1 || level_h[15] != A_DEPTH - 1 || idx_h[15] != A_DEPTH + 1) begin
      failures++;
      $display("FAIL full_push_pop got ready=%0d level=%0d accepted=%0d exp=1/%0d/%0d", ready_h[15], level_h[15], idx_h[15], A_DEPTH - 1, A_DEPTH + 1);
    end
    checks++;
    if (idx_h[16] != 6 || level_h[16] != A_DEPTH) begin
      failures++;
      $display("FAIL bp_accept_after_pop got accepted=%0d level=%0d exp=6/%0d", idx_h[16], level_h[16], A_DEPTH);
    end
    drain_a(to);
    checks++;
    if (to) begin failures++; $display("FAIL bp_drain_timeout got=1 exp=0"); end
    checks++;
    if (got_a.size() != exp_a.size()) begin
      failures++;
      $display("FAIL bp_word_count got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        checks++;
        if (got_a[i] != exp_a[i]) begin
          failures++;
          $display("FAIL bp_word%0d got=%h/%h/%h exp=%h/%h/%h", i, got_a[i].sad, got_a[i].x, got_a[i].y,
                   exp_a[i].sad, exp_a[i].x, exp_a[i].y);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    bit to;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) drive_a(1'b1, $urandom_range(0, 16383), $urandom_range(0, 15), $urandom_range(0, 15));
      else a.in_valid = 1'b0;
      tick();
    end
    checks++;
    if (a.ser_sad_vld !== 1'b1 || a.fifo_level !== 3'd2) begin
      failures++;
      $display("FAIL rstmid_setup got vld=%b level=%0d exp=1/2", a.ser_sad_vld, a.fifo_level);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof} !== 6'b0 ||
        a.fifo_level !== 3'd0 || a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_clear got lanes=%b level=%0d ready=%b exp=0/0/1",
               {a.ser_sad, a.ser_x, a.ser_y, a.ser_sad_vld, a.ser_mv_vld, a.ser_sof}, a.fifo_level, a.in_ready);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    ma_in = 1'b0;
    got_a.delete();
    f = '{$urandom_range(8192, 16383), $urandom_range(8, 15), $urandom_range(0, 7), A_SAD, A_MV};
    drive_a(1'b1, f.sad, f.x, f.y);
    tick();
    a.in_valid = 1'b0;
    tick();
    checks++;
    if ({a.ser_sof, a.ser_sad_vld, a.ser_sad, a.ser_x, a.ser_y} !== 5'b11110) begin
      failures++;
      $display("FAIL rstmid_first_bit got=%b exp=11110", {a.ser_sof, a.ser_sad_vld, a.ser_sad, a.ser_x, a.ser_y});
    end
    drain_a(to);
    checks++;
    if (got_a.size() != 1 || got_a[0] != f) begin
      failures++;
      $display("FAIL rstmid_word got count=%0d exp=1 word=%h/%h/%h", got_a.size(), f.sad, f.x, f.y);
    end
  endtask

  task automatic test_random_params();
    int acc = 0;
    int cyc = 0;
    bit hold = 1'b0;
    bit ready_pre;
    int unsigned s = 0, x = 0, y = 0;
    got_b.delete();
    exp_b.delete();
    mb_bad = 0;
    while (acc < 40 && cyc < 5000) begin
      if (!hold && $urandom_range(0, 2) != 0) begin
        s = $urandom_range(0, 65535);
        x = $urandom_range(0, 63);
        y = $urandom_range(0, 63);
        hold = 1'b1;
      end
      b.in_valid = hold;
      b.in_sad   = 16'(s);
      b.in_mv_x  = 6'(x);
      b.in_mv_y  = 6'(y);
      checks++;
      if (b.in_ready !== (b.fifo_level != 4'(B_DEPTH))) begin
        failures++;
        $display("FAIL rand_in_ready got=%b level=%0d", b.in_ready, b.fifo_level);
      end
      ready_pre = b.in_ready;
      tick();
      cyc++;
      if (hold && ready_pre) begin
        exp_b.push_back('{s, x, y, B_SAD, B_MV});
        acc++;
        hold = 1'b0;
      end
    end
    b.in_valid = 1'b0;
    cyc = 0;
    while ((b.fifo_level != 4'd0 || b.ser_sad_vld) && cyc < 1000) begin
      tick();
      cyc++;
    end
    tick();
    checks++;
    if (cyc >= 1000 || acc != 40) begin
      failures++;
      $display("FAIL rand_progress got accepted=%0d drain=%0d exp=40/<1000", acc, cyc);
    end
    checks++;
    if (got_b.size() != exp_b.size() || mb_bad != 0) begin
      failures++;
      $display("FAIL rand_word_count got=%0d bad=%0d exp=%0d/0", got_b.size(), mb_bad, exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        checks++;
        if (got_b[i] != exp_b[i]) begin
          failures++;
          $display("FAIL rand_word%0d got=%h/%h/%h len=%0d mv=%0d exp=%h/%h/%h len=%0d mv=%0d", i,
                   got_b[i].sad, got_b[i].x, got_b[i].y, got_b[i].len, got_b[i].mvlen,
                   exp_b[i].sad, exp_b[i].x, exp_b[i].y, exp_b[i].len, exp_b[i].mvlen);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    test_random_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
